// File: rtl/dpb_ram.sv
// Dual-port block RAM: one 16384-bit array shared by two independently
// configured ports (width, read mode, write mode, block select).

// Per-port control: activity decode, read latch and optional output register.
module dpb_ram_port #(
  parameter bit          RD_MODE = 1'b0,
  parameter logic [1:0]  WR_MODE = 2'b00,
  parameter int          W       = 16,
  parameter logic [2:0]  BLK     = 3'b000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          oce,
  input  logic          wre,
  input  logic [2:0]    blksel,
  input  logic [15:0]   di,
  input  logic [W-1:0]  old_word,
  output logic          we,
  output logic [15:0]   dout
);
  logic         act;
  logic [W-1:0] rd_lat;
  logic [W-1:0] data;
  logic         unused_di;

  assign act       = ce && (blksel == BLK);
  assign we        = act && wre;
  // Upper data bits are ignored for narrow ports.
  assign unused_di = ^di;

  // Read latch: reads load the addressed word; writes follow the write mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_lat <= '0;
    else if (act) begin
      if (!wre)                  rd_lat <= old_word;
      else if (WR_MODE == 2'b01) rd_lat <= di[W-1:0];
      else if (WR_MODE == 2'b10) rd_lat <= old_word;
    end
  end

  generate
    if (RD_MODE) begin : g_pipe
      logic [W-1:0] out_reg;
      // Output register advances on OCE alone, regardless of CE.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      out_reg <= '0;
        else if (oce) out_reg <= rd_lat;
      end
      assign data = out_reg;
    end else begin : g_byp
      assign data = rd_lat;
    end
  endgenerate

  assign dout = 16'(data);
endmodule

module dpb_ram #(
  parameter bit         READ_MODE0  = 1'b0,
  parameter bit         READ_MODE1  = 1'b0,
  parameter logic [1:0] WRITE_MODE0 = 2'b00,
  parameter logic [1:0] WRITE_MODE1 = 2'b00,
  parameter int         BIT_WIDTH_0 = 16,
  parameter int         BIT_WIDTH_1 = 16,
  parameter logic [2:0] BLK_SEL_0   = 3'b000,
  parameter logic [2:0] BLK_SEL_1   = 3'b000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        OCEA,
  input  logic        OCEB,
  input  logic        WREA,
  input  logic        WREB,
  input  logic [13:0] ADA,
  input  logic [13:0] ADB,
  input  logic [15:0] DIA,
  input  logic [15:0] DIB,
  input  logic [2:0]  BLKSELA,
  input  logic [2:0]  BLKSELB,
  output logic [15:0] DOA,
  output logic [15:0] DOB
);
  // Not cleared by reset; starts at zero on power-up.
  logic [16383:0] mem = '0;

  logic [13:0] off_a, off_b;
  logic        we_a, we_b;
  logic [BIT_WIDTH_0-1:0] old_a;
  logic [BIT_WIDTH_1-1:0] old_b;

  // Widths are powers of two, so the word's first bit is the address with
  // its low log2(W) bits cleared.
  assign off_a = ADA & ~14'(BIT_WIDTH_0 - 1);
  assign off_b = ADB & ~14'(BIT_WIDTH_1 - 1);
  assign old_a = mem[off_a +: BIT_WIDTH_0];
  assign old_b = mem[off_b +: BIT_WIDTH_1];

  dpb_ram_port #(
    .RD_MODE(READ_MODE0), .WR_MODE(WRITE_MODE0), .W(BIT_WIDTH_0), .BLK(BLK_SEL_0)
  ) u_port_a (
    .clk(CLK), .rst(RESET), .ce(CEA), .oce(OCEA), .wre(WREA), .blksel(BLKSELA),
    .di(DIA), .old_word(old_a), .we(we_a), .dout(DOA)
  );

  dpb_ram_port #(
    .RD_MODE(READ_MODE1), .WR_MODE(WRITE_MODE1), .W(BIT_WIDTH_1), .BLK(BLK_SEL_1)
  ) u_port_b (
    .clk(CLK), .rst(RESET), .ce(CEB), .oce(OCEB), .wre(WREB), .blksel(BLKSELB),
    .di(DIB), .old_word(old_b), .we(we_b), .dout(DOB)
  );

  // Array writes; B is applied last so it wins overlapping bits.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (we_a) mem[off_a +: BIT_WIDTH_0] <= DIA[BIT_WIDTH_0-1:0];
      if (we_b) mem[off_b +: BIT_WIDTH_1] <= DIB[BIT_WIDTH_1-1:0];
    end
  end
endmodule

// File: tb/tb_dpb_ram.sv
// Directed bench: u0 is 8/8 bypass/normal on block 0; u1 is 16/16 pipeline
// with port A read-before-write and port B write-through on block 2.
module tb_dpb_ram;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        CEA, CEB, OCEA, OCEB, WREA, WREB;
  logic [13:0] ADA, ADB;
  logic [15:0] DIA, DIB;
  logic [2:0]  BLKSELA, BLKSELB;
  logic [15:0] doa0, dob0, doa1, dob1;
  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  dpb_ram #(
    .READ_MODE0(1'b0), .READ_MODE1(1'b0), .WRITE_MODE0(2'b00), .WRITE_MODE1(2'b00),
    .BIT_WIDTH_0(8), .BIT_WIDTH_1(8), .BLK_SEL_0(3'b000), .BLK_SEL_1(3'b000)
  ) u0 (
    .CLK(CLK), .RESET(RESET), .CEA(CEA), .CEB(CEB), .OCEA(OCEA), .OCEB(OCEB),
    .WREA(WREA), .WREB(WREB), .ADA(ADA), .ADB(ADB), .DIA(DIA), .DIB(DIB),
    .BLKSELA(BLKSELA), .BLKSELB(BLKSELB), .DOA(doa0), .DOB(dob0)
  );

  dpb_ram #(
    .READ_MODE0(1'b1), .READ_MODE1(1'b1), .WRITE_MODE0(2'b10), .WRITE_MODE1(2'b01),
    .BIT_WIDTH_0(16), .BIT_WIDTH_1(16), .BLK_SEL_0(3'b010), .BLK_SEL_1(3'b010)
  ) u1 (
    .CLK(CLK), .RESET(RESET), .CEA(CEA), .CEB(CEB), .OCEA(OCEA), .OCEB(OCEB),
    .WREA(WREA), .WREB(WREB), .ADA(ADA), .ADB(ADB), .DIA(DIA), .DIB(DIB),
    .BLKSELA(BLKSELA), .BLKSELB(BLKSELB), .DOA(doa1), .DOB(dob1)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; CEA = 0; CEB = 0; OCEA = 0; OCEB = 0; WREA = 0; WREB = 0;
    ADA = '0; ADB = '0; DIA = '0; DIB = '0; BLKSELA = 3'd0; BLKSELB = 3'd0;
    #2;
    chk("rst u0 doa", doa0, 16'h0000);
    chk("rst u0 dob", dob0, 16'h0000);
    chk("rst u1 doa", doa1, 16'h0000);
    chk("rst u1 dob", dob1, 16'h0000);
    tick();
    RESET = 1'b0;

    // ---- u0: 8-bit bypass, normal write mode ----
    CEA = 1; CEB = 1;
    tick();
    chk("u0 rd0 a", doa0, 16'h0000);
    chk("u0 rd0 b", dob0, 16'h0000);
    WREA = 1; WREB = 1; ADA = 14'd0;  DIA = 16'h00FE; ADB = 14'd8;  DIB = 16'h00DE;
    tick();
    ADA = 14'd16; DIA = 16'h00BE; ADB = 14'd24; DIB = 16'h00DA;
    tick();
    chk("u0 wm00 hold", doa0, 16'h0000);
    WREA = 0; WREB = 0; ADA = 14'd8; ADB = 14'd16;
    tick();
    chk("u0 rd idx1", doa0, 16'h00DE);
    chk("u0 rd idx2", dob0, 16'h00BE);
    ADA = 14'd24; ADB = 14'd24;
    tick();
    chk("u0 rd idx3 a", doa0, 16'h00DA);
    chk("u0 rd idx3 b", dob0, 16'h00DA);
    ADA = 14'd0; ADB = 14'd0;
    #3;
    chk("u0 hold a", doa0, 16'h00DA);
    chk("u0 hold b", dob0, 16'h00DA);
    tick();
    chk("u0 rd idx0 a", doa0, 16'h00FE);
    chk("u0 rd idx0 b", dob0, 16'h00FE);
    // A reads idx4 while B writes it: old content
    ADA = 14'd32; WREB = 1; ADB = 14'd32; DIB = 16'h0033;
    tick();
    chk("u0 rd vs wr", doa0, 16'h0000);
    // Same-address write collision on idx5
    WREA = 1; WREB = 1; ADA = 14'd40; ADB = 14'd40; DIA = 16'h0011; DIB = 16'h0022;
    tick();
    WREA = 0; WREB = 0; ADA = 14'd40; ADB = 14'd32;
    tick();
    chk("u0 collide b wins", doa0, 16'h0022);
    chk("u0 idx4 written", dob0, 16'h0033);
    // Asynchronous reset mid-operation; write attempted during reset
    #2 RESET = 1'b1;
    #1;
    chk("u0 async rst a", doa0, 16'h0000);
    chk("u0 async rst b", dob0, 16'h0000);
    CEB = 0; WREA = 1; ADA = 14'd0; DIA = 16'h0077;
    tick();
    RESET = 1'b0; WREA = 0;
    tick();
    chk("u0 array kept", doa0, 16'h00FE);
    chk("u0 b idle", dob0, 16'h0000);

    // ---- u1: 16-bit pipeline, A read-before-write, B write-through ----
    BLKSELA = 3'd2; BLKSELB = 3'd2; OCEA = 1; OCEB = 1; CEA = 1; CEB = 1;
    WREA = 1; ADA = 14'd0;  DIA = 16'h1234;
    WREB = 1; ADB = 14'd16; DIB = 16'hABCD;
    tick();
    chk("u1 pipe lat1", dob1, 16'h0000);
    CEA = 0; CEB = 0; WREA = 0; WREB = 0;
    tick();
    chk("u1 wm01 new", dob1, 16'hABCD);
    chk("u1 wm10 old0", doa1, 16'h0000);
    CEA = 1; CEB = 1; ADA = 14'd16; ADB = 14'd0;
    tick();
    chk("u1 rd lat1", doa1, 16'h0000);
    CEA = 0; CEB = 0;
    tick();
    chk("u1 rd lat2 a", doa1, 16'hABCD);
    chk("u1 rd lat2 b", dob1, 16'h1234);
    CEA = 1; ADA = 14'd0; OCEA = 0;
    tick();
    chk("u1 oce0 hold", doa1, 16'hABCD);
    CEA = 0; OCEA = 1;
    tick();
    chk("u1 oce1 load", doa1, 16'h1234);
    CEA = 1; WREA = 1; ADA = 14'd16; DIA = 16'h5555;
    tick();
    CEA = 0; WREA = 0;
    tick();
    chk("u1 wm10 prior", doa1, 16'hABCD);
    // Writes blocked by block-select mismatch and by CE=0
    BLKSELA = 3'd3; CEA = 1; WREA = 1; ADA = 14'd0; DIA = 16'h9999;
    tick();
    BLKSELA = 3'd2; CEA = 0; DIA = 16'h8888;
    tick();
    WREA = 0; CEA = 1;
    tick();
    CEA = 0;
    tick();
    chk("u1 blocked wr", doa1, 16'h1234);
    // Same-address collision: B wins; A (mode 10) sees old, B (mode 01) sees new
    CEA = 1; CEB = 1; WREA = 1; WREB = 1; ADA = 14'd32; ADB = 14'd32;
    DIA = 16'h1111; DIB = 16'h2222;
    tick();
    CEA = 0; CEB = 0; WREA = 0; WREB = 0;
    tick();
    chk("u1 collide a old", doa1, 16'h0000);
    chk("u1 collide b new", dob1, 16'h2222);
    CEA = 1; ADA = 14'd32;
    tick();
    CEA = 0;
    tick();
    chk("u1 collide b wins", doa1, 16'h2222);
    CEA = 1; ADA = 14'd16;
    tick();
    CEA = 0;
    tick();
    chk("u1 rd idx1", doa1, 16'h5555);
    chk("u0 untouched", doa0, 16'h00FE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
